// File: rtl/conv_axil_pkg.sv
// Shared register map, bit indices and FSM state types for the convolution AXI-Lite slave.
package conv_axil_pkg;

  localparam logic [7:0] REG_CTRL     = 8'h00;
  localparam logic [7:0] REG_STATUS   = 8'h04;
  localparam logic [7:0] REG_DONE_CLR = 8'h08;
  localparam logic [7:0] REG_K0       = 8'h10;
  localparam logic [7:0] REG_PIX_IN   = 8'h40;
  localparam logic [7:0] REG_RES_OUT  = 8'h44;

  localparam int NUM_K = 9;

  localparam int CTRL_START  = 0;
  localparam int CTRL_FLUSH  = 1;
  localparam int CTRL_IRQ_EN = 2;

  localparam int ST_BUSY        = 0;
  localparam int ST_DONE        = 1;
  localparam int ST_IN_FULL     = 2;
  localparam int ST_RES_EMPTY   = 3;
  localparam int ST_IN_LVL_LSB  = 8;
  localparam int ST_RES_LVL_LSB = 16;

  typedef enum logic [1:0] {OKAY = 2'b00, SLVERR = 2'b10} resp_t;

  typedef enum logic [1:0] {W_IDLE, W_HAVE_A, W_HAVE_D, W_RESP} wstate_e;
  typedef enum logic {R_IDLE, R_RESP} rstate_e;

endpackage

// File: rtl/conv_sync_fifo.sv
// First-word-fall-through synchronous FIFO with wrap-bit pointers and a synchronous clear.
module conv_sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       clr_i,
  input  logic                       push_i,
  input  logic [WIDTH-1:0]           wdata_i,
  input  logic                       pop_i,
  output logic [WIDTH-1:0]           rdata_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH):0]     level_o
);

  localparam int AW = $clog2(DEPTH);

  logic [DEPTH-1:0][WIDTH-1:0] mem_q;
  logic [AW:0]                 wptr_q, rptr_q;
  logic                        do_push, do_pop;

  assign level_o = wptr_q - rptr_q;
  assign empty_o = (level_o == '0);
  assign full_o  = (level_o == (AW+1)'(DEPTH));
  assign rdata_o = mem_q[rptr_q[AW-1:0]];

  // A pop frees the slot, so a full FIFO still takes a push in the same cycle.
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q  <= '0;
      wptr_q <= '0;
      rptr_q <= '0;
    end else if (clr_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (do_push) begin
        mem_q[wptr_q[AW-1:0]] <= wdata_i;
        wptr_q                <= wptr_q + (AW+1)'(1);
      end
      if (do_pop) rptr_q <= rptr_q + (AW+1)'(1);
    end
  end

endmodule

// File: rtl/conv_axil_slave.sv
// AXI4-Lite control/data slave for the convolution core: registers, pixel/result FIFOs, start/done.
// Optional CONV_AXIL_IRQ_EN adds an irq output and the CTRL IRQ_EN bit.
module conv_axil_slave
  import conv_axil_pkg::*;
#(
  parameter int ADDR_W     = 8,
  parameter int FIFO_DEPTH = 16,
  parameter int KW         = 8
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic [ADDR_W-1:0] s_axi_awaddr,
  input  logic              s_axi_awvalid,
  output logic              s_axi_awready,
  input  logic [31:0]       s_axi_wdata,
  input  logic [3:0]        s_axi_wstrb,
  input  logic              s_axi_wvalid,
  output logic              s_axi_wready,
  output logic [1:0]        s_axi_bresp,
  output logic              s_axi_bvalid,
  input  logic              s_axi_bready,
  input  logic [ADDR_W-1:0] s_axi_araddr,
  input  logic              s_axi_arvalid,
  output logic              s_axi_arready,
  output logic [31:0]       s_axi_rdata,
  output logic [1:0]        s_axi_rresp,
  output logic              s_axi_rvalid,
  input  logic              s_axi_rready,
  output logic              core_start,
  input  logic              core_busy,
  input  logic              core_done,
`ifdef CONV_AXIL_IRQ_EN
  output logic              irq,
`endif
  output logic [9*KW-1:0]   kernel,
  output logic [31:0]       pix_tdata,
  output logic              pix_tvalid,
  input  logic              pix_tready,
  input  logic [31:0]       res_tdata,
  input  logic              res_tvalid,
  output logic              res_tready
);

  localparam int LW = $clog2(FIFO_DEPTH) + 1;

  function automatic logic is_reg(input logic [ADDR_W-1:0] a, input logic [7:0] off);
    return (a & ~ADDR_W'(3)) == ADDR_W'(off);
  endfunction

  wstate_e                    wstate_q;
  rstate_e                    rstate_q;
  logic                       awready_q, wready_q, bvalid_q, arready_q, rvalid_q;
  resp_t                      bresp_q, rresp_q, wr_resp, rd_resp;
  logic [ADDR_W-1:0]          awaddr_q, wr_addr;
  logic [31:0]                wdata_q, wr_data, rdata_q, rd_data, status;
  logic [NUM_K-1:0][KW-1:0]   kernel_q;
  logic                       done_q, start_q, alive_q;
  logic                       aw_hs, w_hs, ar_hs, wr_commit, wr_ctrl, wr_pix;
  logic                       start_d, flush, done_clr;
  logic                       in_push, in_full, in_empty;
  logic                       res_push, res_pop, res_full, res_empty;
  logic [LW-1:0]              in_level, res_level;
  logic [31:0]                res_head;
  logic                       unused_wstrb;

  assign unused_wstrb = ^s_axi_wstrb;

  assign aw_hs     = s_axi_awvalid & awready_q;
  assign w_hs      = s_axi_wvalid & wready_q;
  assign ar_hs     = s_axi_arvalid & arready_q;
  // Commit as soon as both halves are held, whether latched earlier or arriving now.
  assign wr_commit = (wstate_q != W_RESP) & (aw_hs | (wstate_q == W_HAVE_A))
                                          & (w_hs  | (wstate_q == W_HAVE_D));
  assign wr_addr   = aw_hs ? s_axi_awaddr : awaddr_q;
  assign wr_data   = w_hs  ? s_axi_wdata  : wdata_q;

  assign wr_ctrl  = wr_commit & is_reg(wr_addr, REG_CTRL);
  assign wr_pix   = wr_commit & is_reg(wr_addr, REG_PIX_IN);
  assign start_d  = wr_ctrl & wr_data[CTRL_START] & ~core_busy;
  assign flush    = wr_ctrl & wr_data[CTRL_FLUSH];
  assign done_clr = (wr_commit & is_reg(wr_addr, REG_DONE_CLR) & wr_data[0]) | flush | start_d;
  assign in_push  = wr_pix & ~in_full;
  assign wr_resp  = (wr_pix & in_full) ? SLVERR : OKAY;

`ifdef CONV_AXIL_IRQ_EN
  logic irq_en_q, irq_q;
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      irq_en_q <= 1'b0;
      irq_q    <= 1'b0;
    end else begin
      if (wr_ctrl) irq_en_q <= wr_data[CTRL_IRQ_EN];
      irq_q <= done_q & irq_en_q;
    end
  end
  assign irq = irq_q;
`else
  logic irq_en_q;
  assign irq_en_q = 1'b0;
`endif

  always_comb begin
    status                          = '0;
    status[ST_BUSY]                 = core_busy;
    status[ST_DONE]                 = done_q;
    status[ST_IN_FULL]              = in_full;
    status[ST_RES_EMPTY]            = res_empty;
    status[ST_IN_LVL_LSB +: 8]      = 8'(in_level);
    status[ST_RES_LVL_LSB +: 8]     = 8'(res_level);
  end

  always_comb begin
    rd_data = '0;
    rd_resp = OKAY;
    if (is_reg(s_axi_araddr, REG_CTRL)) begin
      rd_data[CTRL_IRQ_EN] = irq_en_q;
    end else if (is_reg(s_axi_araddr, REG_STATUS)) begin
      rd_data = status;
    end else if (is_reg(s_axi_araddr, REG_RES_OUT)) begin
      if (res_empty) rd_resp = SLVERR;
      else           rd_data = res_head;
    end
    for (int i = 0; i < NUM_K; i++)
      if (is_reg(s_axi_araddr, REG_K0 + 8'(4*i))) rd_data = 32'($signed(kernel_q[i]));
  end

  assign res_pop = ar_hs & is_reg(s_axi_araddr, REG_RES_OUT) & ~res_empty;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wstate_q  <= W_IDLE;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      bresp_q   <= OKAY;
      awaddr_q  <= '0;
      wdata_q   <= '0;
    end else begin
      if (aw_hs) awaddr_q <= s_axi_awaddr;
      if (w_hs)  wdata_q  <= s_axi_wdata;
      case (wstate_q)
        W_IDLE, W_HAVE_A, W_HAVE_D: begin
          if (wr_commit) begin
            wstate_q  <= W_RESP;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            bvalid_q  <= 1'b1;
            bresp_q   <= wr_resp;
          end else if (aw_hs) begin
            wstate_q  <= W_HAVE_A;
            awready_q <= 1'b0;
            wready_q  <= 1'b1;
          end else if (w_hs) begin
            wstate_q  <= W_HAVE_D;
            awready_q <= 1'b1;
            wready_q  <= 1'b0;
          end else if (wstate_q == W_IDLE) begin
            awready_q <= 1'b1;
            wready_q  <= 1'b1;
          end
        end
        W_RESP: begin
          if (s_axi_bready) begin
            wstate_q  <= W_IDLE;
            bvalid_q  <= 1'b0;
            awready_q <= 1'b1;
            wready_q  <= 1'b1;
          end
        end
        default: wstate_q <= W_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rstate_q  <= R_IDLE;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rresp_q   <= OKAY;
      rdata_q   <= '0;
    end else begin
      case (rstate_q)
        R_IDLE: begin
          if (ar_hs) begin
            rstate_q  <= R_RESP;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b1;
            rdata_q   <= rd_data;
            rresp_q   <= rd_resp;
          end else begin
            arready_q <= 1'b1;
          end
        end
        R_RESP: begin
          if (s_axi_rready) begin
            rstate_q  <= R_IDLE;
            rvalid_q  <= 1'b0;
            arready_q <= 1'b1;
          end
        end
        default: rstate_q <= R_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      kernel_q <= '0;
      done_q   <= 1'b0;
      start_q  <= 1'b0;
      alive_q  <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_K; i++)
        if (wr_commit && is_reg(wr_addr, REG_K0 + 8'(4*i))) kernel_q[i] <= wr_data[KW-1:0];
      // A done event landing with any clear still leaves the flag set.
      done_q  <= core_done | (done_q & ~done_clr);
      start_q <= start_d;
      alive_q <= 1'b1;
    end
  end

  assign res_push = res_tvalid & res_tready;

  conv_sync_fifo #(.WIDTH(32), .DEPTH(FIFO_DEPTH)) u_in_fifo (
    .clk    (clk),
    .rst_n  (resetn),
    .clr_i  (flush),
    .push_i (in_push),
    .wdata_i(wr_data),
    .pop_i  (pix_tvalid & pix_tready),
    .rdata_o(pix_tdata),
    .full_o (in_full),
    .empty_o(in_empty),
    .level_o(in_level)
  );

  conv_sync_fifo #(.WIDTH(32), .DEPTH(FIFO_DEPTH)) u_res_fifo (
    .clk    (clk),
    .rst_n  (resetn),
    .clr_i  (flush),
    .push_i (res_push),
    .wdata_i(res_tdata),
    .pop_i  (res_pop),
    .rdata_o(res_head),
    .full_o (res_full),
    .empty_o(res_empty),
    .level_o(res_level)
  );

  assign s_axi_awready = awready_q;
  assign s_axi_wready  = wready_q;
  assign s_axi_bvalid  = bvalid_q;
  assign s_axi_bresp   = bresp_q;
  assign s_axi_arready = arready_q;
  assign s_axi_rvalid  = rvalid_q;
  assign s_axi_rresp   = rresp_q;
  assign s_axi_rdata   = rdata_q;
  assign core_start    = start_q;
  assign kernel        = kernel_q;
  assign pix_tvalid    = ~in_empty;
  assign res_tready    = alive_q & ~res_full;

endmodule

// File: tb/tb_conv_axil_slave.sv
// Directed bench for conv_axil_slave: register map, FIFOs, write/read handshakes, start/done.
module tb_conv_axil_slave;

  logic        clk = 1'b0, resetn = 1'b0;
  logic [7:0]  awaddr = '0, araddr = '0;
  logic        awvalid = 0, wvalid = 0, bready = 0, arvalid = 0, rready = 0;
  logic        awready, wready, bvalid, arready, rvalid;
  logic [31:0] wdata = '0, rdata;
  logic [3:0]  wstrb = 4'hF;
  logic [1:0]  bresp, rresp;
  logic        core_start, core_busy = 0, core_done = 0;
  logic [71:0] kernel;
  logic [31:0] pix_tdata, res_tdata = '0;
  logic        pix_tvalid, pix_tready = 0, res_tvalid = 0, res_tready;

  int vectors = 0, miscompares = 0, start_cnt = 0;

  conv_axil_slave dut (
    .clk(clk), .resetn(resetn),
    .s_axi_awaddr(awaddr), .s_axi_awvalid(awvalid), .s_axi_awready(awready),
    .s_axi_wdata(wdata), .s_axi_wstrb(wstrb), .s_axi_wvalid(wvalid), .s_axi_wready(wready),
    .s_axi_bresp(bresp), .s_axi_bvalid(bvalid), .s_axi_bready(bready),
    .s_axi_araddr(araddr), .s_axi_arvalid(arvalid), .s_axi_arready(arready),
    .s_axi_rdata(rdata), .s_axi_rresp(rresp), .s_axi_rvalid(rvalid), .s_axi_rready(rready),
    .core_start(core_start), .core_busy(core_busy), .core_done(core_done),
    .kernel(kernel),
    .pix_tdata(pix_tdata), .pix_tvalid(pix_tvalid), .pix_tready(pix_tready),
    .res_tdata(res_tdata), .res_tvalid(res_tvalid), .res_tready(res_tready)
  );

  always #5 clk = ~clk;
  always @(negedge clk) if (core_start) start_cnt++;

  task automatic axi_write(input logic [7:0] a, input logic [31:0] d, output logic [1:0] resp);
    int n; logic ad, wd, af, wf;
    @(negedge clk);
    awaddr = a; awvalid = 1; wdata = d; wvalid = 1; bready = 1; ad = 0; wd = 0; n = 0;
    while (!(ad && wd) && n < 50) begin
      af = awvalid && awready; wf = wvalid && wready;
      @(negedge clk); n++;
      if (af) begin awvalid = 0; ad = 1; end
      if (wf) begin wvalid = 0; wd = 1; end
    end
    awvalid = 0; wvalid = 0; n = 0;
    while (!bvalid && n < 50) begin @(negedge clk); n++; end
    if (!bvalid) begin
      vectors++; miscompares++;
      $display("FAIL write_timeout addr=%h", a);
    end
    resp = bresp;
    @(negedge clk); bready = 0;
  endtask

  task automatic axi_read(input logic [7:0] a, output logic [31:0] d, output logic [1:0] resp);
    int n;
    @(negedge clk);
    araddr = a; arvalid = 1; rready = 1; n = 0;
    while (!arready && n < 50) begin @(negedge clk); n++; end
    @(negedge clk); arvalid = 0; n = 0;
    while (!rvalid && n < 50) begin @(negedge clk); n++; end
    if (!rvalid) begin
      vectors++; miscompares++;
      $display("FAIL read_timeout addr=%h", a);
    end
    d = rdata; resp = rresp;
    @(negedge clk); rready = 0;
  endtask

  task automatic pulse_done();
    @(negedge clk); core_done = 1;
    @(negedge clk); core_done = 0;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    vectors++;
    if ({awready, wready, arready, bvalid, rvalid, core_start, pix_tvalid, res_tready} !== 8'h00) begin
      miscompares++;
      $display("FAIL reset_handshake got=%b exp=00000000",
               {awready, wready, arready, bvalid, rvalid, core_start, pix_tvalid, res_tready});
    end
    vectors++;
    if ({rdata, rresp, bresp} !== 36'h0) begin
      miscompares++; $display("FAIL reset_data rdata=%h rresp=%b bresp=%b exp 0", rdata, rresp, bresp);
    end
    vectors++;
    if (kernel !== 72'h0) begin miscompares++; $display("FAIL reset_kernel got=%h exp=0", kernel); end
    resetn = 1;
    repeat (2) @(negedge clk);
    vectors++;
    if ({awready, wready, arready, res_tready} !== 4'hF) begin
      miscompares++; $display("FAIL post_reset_ready got=%b exp=1111", {awready, wready, arready, res_tready});
    end
  endtask

  task automatic test_kernel();
    logic [1:0] r; logic [31:0] d;
    axi_write(8'h10, 32'h12, r);
    axi_write(8'h30, 32'hFF, r);
    axi_read(8'h10, d, r);
    vectors++;
    if (d !== 32'h12 || r !== 2'b00) begin miscompares++; $display("FAIL k0_read got=%h/%b exp=00000012/00", d, r); end
    axi_read(8'h30, d, r);
    vectors++;
    if (d !== 32'hFFFFFFFF) begin miscompares++; $display("FAIL k8_sext got=%h exp=ffffffff", d); end
    vectors++;
    if (kernel[7:0] !== 8'h12 || kernel[71:64] !== 8'hFF) begin
      miscompares++; $display("FAIL kernel_port k0=%h k8=%h exp 12/ff", kernel[7:0], kernel[71:64]);
    end
  endtask

  task automatic test_pix_fifo();
    logic [1:0] r; logic [31:0] d; int got, n;
    pix_tready = 0;
    for (int i = 0; i < 17; i++) begin
      axi_write(8'h40, 32'h100 + i, r);
      vectors++;
      if (r !== ((i < 16) ? 2'b00 : 2'b10)) begin
        miscompares++; $display("FAIL pix_push_resp idx=%0d got=%b exp=%b", i, r, (i < 16) ? 2'b00 : 2'b10);
      end
    end
    axi_read(8'h04, d, r);
    vectors++;
    if (d[15:8] !== 8'd16 || d[2] !== 1'b1) begin
      miscompares++; $display("FAIL pix_full_status lvl=%0d full=%b exp 16/1", d[15:8], d[2]);
    end
    pix_tready = 1; got = 0; n = 0;
    while (got < 16 && n < 60) begin
      if (pix_tvalid) begin
        vectors++;
        if (pix_tdata !== 32'h100 + got) begin
          miscompares++; $display("FAIL pix_order idx=%0d got=%h exp=%h", got, pix_tdata, 32'h100 + got);
        end
        got++;
      end
      @(negedge clk); n++;
    end
    pix_tready = 0;
    vectors++;
    if (got != 16 || pix_tvalid !== 1'b0) begin
      miscompares++; $display("FAIL pix_drain words=%0d tvalid=%b exp 16/0", got, pix_tvalid);
    end
  endtask

  task automatic test_aw_early();
    logic [1:0] r; logic [31:0] d;
    @(negedge clk); awaddr = 8'h14; awvalid = 1; bready = 0;
    vectors++;
    if (awready !== 1'b1) begin miscompares++; $display("FAIL aw_early_ready got=%b exp=1", awready); end
    @(negedge clk); awvalid = 0;
    repeat (2) @(negedge clk);
    vectors++;
    if ({awready, wready, bvalid} !== 3'b010) begin
      miscompares++; $display("FAIL have_a_state got=%b exp=010", {awready, wready, bvalid});
    end
    wdata = 32'h5; wvalid = 1;
    @(negedge clk); wvalid = 0;
    vectors++;
    if (bvalid !== 1'b1 || bresp !== 2'b00) begin
      miscompares++; $display("FAIL late_w_bvalid got=%b/%b exp=1/00", bvalid, bresp);
    end
    awaddr = 8'h18; awvalid = 1; wdata = 32'h77; wvalid = 1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      vectors++;
      if ({bvalid, awready, wready} !== 3'b100) begin
        miscompares++; $display("FAIL bresp_hold cyc=%0d got=%b exp=100", k, {bvalid, awready, wready});
      end
    end
    awvalid = 0; wvalid = 0; bready = 1;
    @(negedge clk); bready = 0;
    vectors++;
    if (bvalid !== 1'b0) begin miscompares++; $display("FAIL bvalid_release got=%b exp=0", bvalid); end
    axi_read(8'h14, d, r);
    vectors++;
    if (d !== 32'h5) begin miscompares++; $display("FAIL k1_commit got=%h exp=00000005", d); end
    axi_read(8'h18, d, r);
    vectors++;
    if (d !== 32'h0) begin miscompares++; $display("FAIL no_second_write got=%h exp=0", d); end
  endtask

  task automatic test_start();
    logic [1:0] r; logic [31:0] d; int s0;
    core_busy = 0; s0 = start_cnt;
    axi_write(8'h00, 32'h1, r);
    repeat (3) @(negedge clk);
    vectors++;
    if (start_cnt - s0 != 1) begin miscompares++; $display("FAIL start_idle pulses=%0d exp=1", start_cnt - s0); end
    core_busy = 1; s0 = start_cnt;
    axi_write(8'h00, 32'h1, r);
    repeat (3) @(negedge clk);
    vectors++;
    if (start_cnt - s0 != 0) begin miscompares++; $display("FAIL start_busy pulses=%0d exp=0", start_cnt - s0); end
    axi_read(8'h04, d, r);
    vectors++;
    if (d[0] !== 1'b1) begin miscompares++; $display("FAIL status_busy got=%b exp=1", d[0]); end
    core_busy = 0;
    axi_write(8'h00, 32'h4, r);
    axi_read(8'h00, d, r);
    vectors++;
    if (d !== 32'h0) begin miscompares++; $display("FAIL ctrl_read got=%h exp=0", d); end
  endtask

  task automatic test_done();
    logic [1:0] r; logic [31:0] d;
    pulse_done();
    axi_read(8'h04, d, r);
    vectors++;
    if (d[1] !== 1'b1) begin miscompares++; $display("FAIL done_set got=%b exp=1", d[1]); end
    axi_write(8'h08, 32'h1, r);
    axi_read(8'h04, d, r);
    vectors++;
    if (d[1] !== 1'b0) begin miscompares++; $display("FAIL done_clr got=%b exp=0", d[1]); end
    @(negedge clk);
    awaddr = 8'h08; awvalid = 1; wdata = 32'h1; wvalid = 1; bready = 1; core_done = 1;
    @(negedge clk); awvalid = 0; wvalid = 0; core_done = 0;
    @(negedge clk); bready = 0;
    axi_read(8'h04, d, r);
    vectors++;
    if (d[1] !== 1'b1) begin miscompares++; $display("FAIL done_set_wins got=%b exp=1", d[1]); end
  endtask

  task automatic test_results();
    logic [1:0] r; logic [31:0] d;
    @(negedge clk);
    vectors++;
    if (res_tready !== 1'b1) begin miscompares++; $display("FAIL res_tready got=%b exp=1", res_tready); end
    res_tvalid = 1; res_tdata = 32'hA;
    @(negedge clk); res_tdata = 32'hB;
    @(negedge clk); res_tvalid = 0;
    axi_read(8'h04, d, r);
    vectors++;
    if (d[23:16] !== 8'd2 || d[3] !== 1'b0) begin
      miscompares++; $display("FAIL res_level lvl=%0d empty=%b exp 2/0", d[23:16], d[3]);
    end
    axi_read(8'h44, d, r);
    vectors++;
    if (d !== 32'hA || r !== 2'b00) begin miscompares++; $display("FAIL res_pop0 got=%h/%b exp=0000000a/00", d, r); end
    axi_read(8'h44, d, r);
    vectors++;
    if (d !== 32'hB || r !== 2'b00) begin miscompares++; $display("FAIL res_pop1 got=%h/%b exp=0000000b/00", d, r); end
    axi_read(8'h44, d, r);
    vectors++;
    if (d !== 32'h0 || r !== 2'b10) begin miscompares++; $display("FAIL res_empty_pop got=%h/%b exp=0/10", d, r); end
  endtask

  task automatic test_flush();
    logic [1:0] r; logic [31:0] d;
    pix_tready = 0;
    axi_write(8'h40, 32'h55, r);
    axi_write(8'h40, 32'h66, r);
    @(negedge clk); res_tvalid = 1; res_tdata = 32'h99;
    @(negedge clk); res_tvalid = 0;
    pulse_done();
    axi_write(8'h00, 32'h2, r);
    axi_read(8'h04, d, r);
    vectors++;
    if (d[23:0] !== 24'h00_00_08) begin
      miscompares++; $display("FAIL flush_status got=%h exp=000008", d[23:0]);
    end
    vectors++;
    if (pix_tvalid !== 1'b0 || kernel[7:0] !== 8'h12) begin
      miscompares++; $display("FAIL flush_side tvalid=%b k0=%h exp 0/12", pix_tvalid, kernel[7:0]);
    end
    @(negedge clk); res_tvalid = 1; res_tdata = 32'hC;
    @(negedge clk); res_tvalid = 0;
    axi_read(8'h44, d, r);
    vectors++;
    if (d !== 32'hC || r !== 2'b00) begin miscompares++; $display("FAIL post_flush_res got=%h/%b exp=0000000c/00", d, r); end
  endtask

  task automatic test_unmapped();
    logic [1:0] r; logic [31:0] d;
    axi_write(8'h3C, 32'hDEAD, r);
    vectors++;
    if (r !== 2'b00) begin miscompares++; $display("FAIL unmapped_wr got=%b exp=00", r); end
    axi_read(8'h3C, d, r);
    vectors++;
    if (d !== 32'h0 || r !== 2'b00) begin miscompares++; $display("FAIL unmapped_rd got=%h/%b exp=0/00", d, r); end
  endtask

  task automatic test_reset_mid();
    @(negedge clk); awaddr = 8'h1C; awvalid = 1;
    @(negedge clk); awvalid = 0; resetn = 0;
    @(negedge clk);
    vectors++;
    if ({awready, wready, bvalid} !== 3'b000 || kernel !== 72'h0) begin
      miscompares++; $display("FAIL mid_reset hs=%b kernel=%h exp 000/0", {awready, wready, bvalid}, kernel);
    end
    resetn = 1;
    repeat (2) @(negedge clk);
    vectors++;
    if ({awready, wready} !== 2'b11) begin
      miscompares++; $display("FAIL mid_reset_idle got=%b exp=11", {awready, wready});
    end
  endtask

  initial begin
    test_reset();
    test_kernel();
    test_pix_fifo();
    test_aw_early();
    test_start();
    test_done();
    test_results();
    test_flush();
    test_unmapped();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/conv_axil_slave.md
Name: conv_axil_slave

Overview:
- AXI4-Lite slave on the picorv32 AXI master bus; directly downstream of the CPU and upstream of the convolution core.
- Holds control/status and 3x3 kernel registers, pushes CPU-written pixel words into an input FIFO that streams to the core, and buffers core results in an output FIFO the CPU pops by reading.
- Generates a single-cycle start pulse and captures the core's done event.

Parameters:
- ADDR_W, 8, AXI byte-address width; low 2 bits ignored.
- FIFO_DEPTH, 16, entries per FIFO; power of 2, minimum 2.
- KW, 8, signed kernel coefficient width.

Ports:
- clk  in  1  system clock
- resetn  in  1  reset, asynchronous assert, active-low
- s_axi_awaddr/awvalid/awready  in/in/out  ADDR_W/1/1  write address channel
- s_axi_wdata/wstrb/wvalid/wready  in/in/in/out  32/4/1/1  write data channel; wstrb ignored
- s_axi_bresp/bvalid/bready  out/out/in  2/1/1  write response channel
- s_axi_araddr/arvalid/arready  in/in/out  ADDR_W/1/1  read address channel
- s_axi_rdata/rresp/rvalid/rready  out/out/out/in  32/2/1/1  read data channel
- core_start  out  1  one-cycle start pulse
- core_busy  in  1  core running
- core_done  in  1  one-cycle completion pulse
- kernel  out  9*KW  coefficients k0..k8; k0 occupies the LSBs
- pix_tdata/pix_tvalid/pix_tready  out/out/in  32/1/1  pixel stream to core
- res_tdata/res_tvalid/res_tready  in/in/out  32/1/1  result stream from core

Behaviour:
- Reset (resetn low): all ready/valid outputs 0; bresp, rresp, rdata 0; core_start 0; kernel 0; both FIFOs empty; done flag 0.
- Register map (word offsets):
  - 0x00 CTRL: bit0 START (write 1 pulses core_start only if core_busy=0, otherwise ignored; always reads 0); bit1 FLUSH (self-clearing; empties both FIFOs and clears done; kernel is preserved).
  - 0x04 STATUS, RO: bit0 core_busy; bit1 done; bit2 in-FIFO full; bit3 res-FIFO empty; [15:8] in-FIFO level; [23:16] res-FIFO level.
  - 0x08 DONE_CLR: writing 1 to bit0 clears done.
  - 0x10-0x30 K0..K8: RW; low KW bits stored; reads return the value sign-extended to 32 bits.
  - 0x40 PIX_IN, WO: pushes the word into the in-FIFO. If the FIFO is full: BRESP=SLVERR (2'b10) and the word is dropped.
  - 0x44 RES_OUT, RO: pops the res-FIFO head. If the FIFO is empty: RDATA=0, RRESP=SLVERR.
  - Any other address: reads return 0 with OKAY; writes are ignored with OKAY.
- Write FSM, states W_IDLE, W_HAVE_A, W_HAVE_D, W_RESP:
  - AW and W are accepted independently; awready/wready are high in W_IDLE and for whichever channel is still missing.
  - When both are held, the write commits in that cycle and bvalid rises the next cycle.
  - bvalid is held until bready; no new AW/W is accepted while in W_RESP.
- Read FSM, states R_IDLE, R_RESP:
  - arready=1 in R_IDLE; on the AR handshake, rdata/rresp are registered and rvalid rises the next cycle.
  - Outputs are held until rready. A RES_OUT pop occurs at the AR handshake.
- Pixel stream: pix_tvalid = in-FIFO not empty; pix_tdata = head (first-word-fall-through). A pushed word is visible on pix_tdata one cycle after its write commits.
- Result stream: res_tready = res-FIFO not full.
- FIFOs:
  - Simultaneous push and pop is legal at any level, including full (level unchanged) and empty (the pushed word is not popped that cycle).
  - Pointers are log2(FIFO_DEPTH)+1 bits wide and wrap naturally.
- Done flag:
  - Set by core_done; cleared by DONE_CLR, FLUSH, or START.
  - If a set and a clear occur in the same cycle, the set wins.
- FLUSH while the core is busy: both FIFOs are emptied; the core is not stopped; later results are accepted normally.
- Reset asserted mid-transaction: the handshake is abandoned and all state returns to reset values.

Optional Feature:
- Macro CONV_AXIL_IRQ_EN.
- Defined:
  - Adds output port irq (1 bit) and CTRL bit2 IRQ_EN (RW, reset 0).
  - irq = done & IRQ_EN, registered (one cycle after done sets).
- Undefined: no irq port; CTRL bit2 reads 0 and writes to it are ignored.

Decomposition:
- Package conv_axil_pkg:
  - register offset localparams;
  - resp_t enum (OKAY=2'b00, SLVERR=2'b10);
  - CTRL and STATUS bit-index constants;
  - write/read FSM state enums.
- Sub-module conv_sync_fifo (parameters WIDTH, DEPTH; FWFT; push/pop/full/empty/level), instantiated twice.

Test Plan:
- Write 0x12 to K0 and 0xFF to K8, then read both -> rdata 0x00000012 and 0xFFFFFFFF; kernel[7:0]=0x12, kernel[71:64]=0xFF.
- With pix_tready=0, write PIX_IN 17 times (depth 16) -> first 16 return OKAY, 17th returns SLVERR; STATUS[15:8]=16 and bit2=1; release pix_tready -> 16 words emerge in order.
- Issue AW three cycles before W, then hold bready=0 for 4 cycles -> one commit, bvalid stays high until bready, no second write accepted.
- Write CTRL=1 with core_busy=0 -> exactly one core_start cycle; repeat with core_busy=1 -> no pulse.
- Drive core_done on the same cycle as a DONE_CLR commit -> STATUS bit1=1.
- Core pushes results 0xA, 0xB; read RES_OUT three times -> 0xA OKAY, 0xB OKAY, 0 SLVERR.
